// File: rtl/encoder_pkg.sv
// Shared types and constants for the rotary-encoder value block.
//
// accel_state_t : acceleration level (x1, x4, x16 step multiplier)
// ACCEL_SHIFT   : left-shift per acceleration level (2 -> x4 per level)
// accel_raise   : next level up, saturating at ACC2
package encoder_pkg;

  typedef enum logic [1:0] {
    ACC0 = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } accel_state_t;

  localparam int unsigned ACCEL_SHIFT = 2;

  function automatic accel_state_t accel_raise(input accel_state_t lvl);
    accel_state_t nxt;
    unique case (lvl)
      ACC0:    nxt = ACC1;
      ACC1:    nxt = ACC2;
      default: nxt = ACC2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/encoder_accel.sv
// Rotation acceleration tracker.
//
// Counts consecutive same-direction detents and raises the acceleration level
// every ACCEL_COUNT detents (saturating at ACC2). A direction reversal or an
// idle gap of ACCEL_WINDOW clocks drops back to ACC0.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   cw        in   clockwise detent pulse
//   ccw       in   counter-clockwise detent pulse
//   clr       in   force level 0 / count 0; suppresses this cycle's detent
//   accel_lvl out  registered acceleration level
//   step_lvl  out  level to apply to the detent in this cycle (ACC0 on reversal)
module encoder_accel
  import encoder_pkg::*;
#(
  parameter int unsigned ACCEL_COUNT  = 4,
  parameter int unsigned ACCEL_WINDOW = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cw,
  input  logic         ccw,
  input  logic         clr,
  output accel_state_t accel_lvl,
  output accel_state_t step_lvl
);

  localparam int unsigned TW = $clog2(ACCEL_WINDOW + 1);
  localparam int unsigned CW = (ACCEL_COUNT > 1) ? $clog2(ACCEL_COUNT) : 1;

  localparam logic [TW-1:0] WinLast = TW'(ACCEL_WINDOW - 1);
  localparam logic [TW-1:0] WinMax  = TW'(ACCEL_WINDOW);
  localparam logic [CW-1:0] CntLast = CW'(ACCEL_COUNT - 1);

  accel_state_t  lvl_q, lvl_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_valid_q, dir_valid_d;
  logic          dir_cw_q, dir_cw_d;

  logic          event_v;
  logic          reversal;
  accel_state_t  base_lvl;
  logic [CW-1:0] base_cnt;

  // A detent is exactly one of cw/ccw; a load in the same cycle swallows it.
  assign event_v  = (cw ^ ccw) & ~clr;
  assign reversal = event_v & dir_valid_q & (dir_cw_q != cw);

  // A reversal restarts counting from scratch before this detent is counted.
  assign base_lvl = reversal ? ACC0 : lvl_q;
  assign base_cnt = reversal ? '0 : cnt_q;

  always_comb begin
    lvl_d       = lvl_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    dir_valid_d = dir_valid_q;
    dir_cw_d    = dir_cw_q;

    if (event_v) begin
      timer_d     = '0;
      dir_valid_d = 1'b1;
      dir_cw_d    = cw;
      if (base_cnt == CntLast) begin
        cnt_d = '0;
        lvl_d = accel_raise(base_lvl);
      end else begin
        cnt_d = base_cnt + CW'(1);
        lvl_d = base_lvl;
      end
    end else if (timer_q != WinMax) begin
      timer_d = timer_q + TW'(1);
      // Window expiry: forget level, count and direction so the next
      // detent starts fresh without a reversal penalty.
      if (timer_q == WinLast) begin
        lvl_d       = ACC0;
        cnt_d       = '0;
        dir_valid_d = 1'b0;
      end
    end

    if (clr) begin
      lvl_d = ACC0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q       <= ACC0;
      cnt_q       <= '0;
      timer_q     <= '0;
      dir_valid_q <= 1'b0;
      dir_cw_q    <= 1'b0;
    end else begin
      lvl_q       <= lvl_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      dir_valid_q <= dir_valid_d;
      dir_cw_q    <= dir_cw_d;
    end
  end

  assign accel_lvl = lvl_q;
  assign step_lvl  = base_lvl;

endmodule

// File: rtl/encoder_value.sv
// Bounded setpoint register driven by rotary-encoder pulses.
//
// Each detent adds/subtracts a step of (FINE_STEP or COARSE_STEP) scaled by
// x1/x4/x16 acceleration. Results beyond [MIN,MAX] clamp or wrap to the
// opposite bound. prs toggles fine/coarse; load overwrites the value.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   cw        in   clockwise detent pulse
//   ccw       in   counter-clockwise detent pulse
//   prs       in   button press pulse (toggles coarse)
//   load      in   load pulse, highest priority
//   load_val  in   value to load, clamped to [MIN,MAX]
//   value     out  registered setpoint
//   changed   out  one-cycle strobe when value takes a new, different value
//   coarse    out  coarse step selected
//   accel_lvl out  acceleration level 0..2
//   at_min    out  value == MIN
//   at_max    out  value == MAX
module encoder_value
  import encoder_pkg::*;
#(
  parameter int unsigned W            = 16,
  parameter int unsigned MIN          = 0,
  parameter int unsigned MAX          = 1000,
  parameter int unsigned INIT         = 500,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned FINE_STEP    = 1,
  parameter int unsigned COARSE_STEP  = 10,
  parameter int unsigned ACCEL_COUNT  = 4,
  parameter int unsigned ACCEL_WINDOW = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cw,
  input  logic         ccw,
  input  logic         prs,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         changed,
  output logic         coarse,
  output logic [1:0]   accel_lvl,
  output logic         at_min,
  output logic         at_max
);

  // Six guard bits cover a x16 step on top of a full-range value.
  localparam int unsigned XW = W + 6;

  localparam logic [W-1:0]  MinV    = W'(MIN);
  localparam logic [W-1:0]  MaxV    = W'(MAX);
  localparam logic [W-1:0]  InitV   = W'(INIT);
  localparam logic [XW-1:0] MinX    = XW'(MIN);
  localparam logic [XW-1:0] MaxX    = XW'(MAX);
  localparam logic [XW-1:0] FineX   = XW'(FINE_STEP);
  localparam logic [XW-1:0] CoarseX = XW'(COARSE_STEP);
  localparam bit            DoWrap  = (WRAP != 0);

  logic [W-1:0]  value_q, value_d;
  logic          changed_q, changed_d;
  logic          coarse_q, coarse_d;

  accel_state_t  lvl_reg;
  accel_state_t  step_lvl;

  logic [XW-1:0] value_x;
  logic [XW-1:0] base_step;
  logic [XW-1:0] step;
  logic [XW-1:0] sum;
  logic [XW-1:0] diff;
  logic          over;
  logic          under;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  load_clamped;

  encoder_accel #(
    .ACCEL_COUNT  (ACCEL_COUNT),
    .ACCEL_WINDOW (ACCEL_WINDOW)
  ) u_accel (
    .clk       (clk),
    .rst       (rst),
    .cw        (cw),
    .ccw       (ccw),
    .clr       (load),
    .accel_lvl (lvl_reg),
    .step_lvl  (step_lvl)
  );

  // Step uses the coarse setting registered before this cycle's prs.
  always_comb begin
    base_step = coarse_q ? CoarseX : FineX;
    unique case (step_lvl)
      ACC0:    step = base_step;
      ACC1:    step = base_step << ACCEL_SHIFT;
      ACC2:    step = base_step << (2 * ACCEL_SHIFT);
      default: step = base_step;
    endcase
  end

  assign value_x = XW'(value_q);
  assign sum     = value_x + step;
  assign diff    = value_x - step;
  assign over    = (sum > MaxX);
  // Check step > value first so the unsigned difference never wraps silently.
  assign under   = (step > value_x) || (diff < MinX);

  assign inc_val = over  ? (DoWrap ? MinV : MaxV) : sum[W-1:0];
  assign dec_val = under ? (DoWrap ? MaxV : MinV) : diff[W-1:0];

  always_comb begin
    load_clamped = load_val;
    if (load_val < MinV) begin
      load_clamped = MinV;
    end else if (load_val > MaxV) begin
      load_clamped = MaxV;
    end
  end

  always_comb begin
    value_d  = value_q;
    coarse_d = coarse_q;
    if (load) begin
      value_d = load_clamped;
    end else begin
      if (prs) begin
        coarse_d = ~coarse_q;
      end
      if (cw && !ccw) begin
        value_d = inc_val;
      end else if (ccw && !cw) begin
        value_d = dec_val;
      end
    end
    changed_d = (value_d != value_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q   <= InitV;
      changed_q <= 1'b0;
      coarse_q  <= 1'b0;
    end else begin
      value_q   <= value_d;
      changed_q <= changed_d;
      coarse_q  <= coarse_d;
    end
  end

  assign value     = value_q;
  assign changed   = changed_q;
  assign coarse    = coarse_q;
  assign accel_lvl = lvl_reg;
  assign at_min    = (value_q == MinV);
  assign at_max    = (value_q == MaxV);

endmodule

// File: tb/tb_encoder_value.sv
// Bench for encoder_value: a clamping and a wrapping instance share stimulus;
// each is tracked by its own reference model and checked every cycle.
module tb_encoder_value;

  localparam int MIN  = 0;
  localparam int MAX  = 1000;
  localparam int INIT = 500;
  localparam int WIN  = 100;
  localparam int ACNT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cw, ccw, prs, load;
  logic [15:0] load_val;

  logic [15:0] value_c, value_w;
  logic        changed_c, changed_w, coarse_c, coarse_w;
  logic [1:0]  lvl_c, lvl_w;
  logic        at_min_c, at_min_w, at_max_c, at_max_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encoder_value #(.WRAP(0), .ACCEL_WINDOW(WIN)) dut_c (
    .clk(clk), .rst(rst), .cw(cw), .ccw(ccw), .prs(prs), .load(load), .load_val(load_val),
    .value(value_c), .changed(changed_c), .coarse(coarse_c), .accel_lvl(lvl_c),
    .at_min(at_min_c), .at_max(at_max_c)
  );

  encoder_value #(.WRAP(1), .ACCEL_WINDOW(WIN)) dut_w (
    .clk(clk), .rst(rst), .cw(cw), .ccw(ccw), .prs(prs), .load(load), .load_val(load_val),
    .value(value_w), .changed(changed_w), .coarse(coarse_w), .accel_lvl(lvl_w),
    .at_min(at_min_w), .at_max(at_max_w)
  );

  // Reference model: plain integer arithmetic over the behavioural rules.
  typedef struct {
    int val;
    bit coarse;
    int lvl;
    int cnt;
    int timer;
    int dir;      // 0 none, +1 cw, -1 ccw
    bit changed;
  } mstate_t;

  mstate_t mc, mw;

  function automatic mstate_t mreset();
    mstate_t s;
    s.val = INIT; s.coarse = 0; s.lvl = 0; s.cnt = 0; s.timer = 0; s.dir = 0; s.changed = 0;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input bit icw, input bit iccw,
                                    input bit iprs, input bit ild, input int lv, input bit wrap);
    mstate_t n;
    int ev, lu, c, step, t;
    bit rev;
    n  = s;
    ev = (icw && !iccw) ? 1 : ((iccw && !icw) ? -1 : 0);
    if (ild) begin
      n.val = (lv < MIN) ? MIN : ((lv > MAX) ? MAX : lv);
      n.lvl = 0;
      n.cnt = 0;
    end else begin
      if (iprs) n.coarse = !s.coarse;
      if (ev != 0) begin
        rev = (s.dir != 0) && (s.dir != ev);
        lu  = rev ? 0 : s.lvl;
        c   = (rev ? 0 : s.cnt) + 1;
        if (c == ACNT) begin
          n.cnt = 0;
          n.lvl = (lu < 2) ? lu + 1 : 2;
        end else begin
          n.cnt = c;
          n.lvl = lu;
        end
        n.dir   = ev;
        n.timer = 0;
        step = (s.coarse ? 10 : 1) * (4 ** lu);
        t = s.val + ev * step;
        if (t > MAX)      n.val = wrap ? MIN : MAX;
        else if (t < MIN) n.val = wrap ? MAX : MIN;
        else              n.val = t;
      end
    end
    if (ild || ev == 0) begin
      if (s.timer < WIN) begin
        n.timer = s.timer + 1;
        if (n.timer == WIN) begin
          n.lvl = 0; n.cnt = 0; n.dir = 0;
        end
      end
    end
    n.changed = (n.val != s.val);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_models();
    chk("c.value",   32'(value_c),   32'(mc.val));
    chk("c.changed", 32'(changed_c), 32'(mc.changed));
    chk("c.coarse",  32'(coarse_c),  32'(mc.coarse));
    chk("c.accel",   32'(lvl_c),     32'(mc.lvl));
    chk("c.at_min",  32'(at_min_c),  32'(mc.val == MIN));
    chk("c.at_max",  32'(at_max_c),  32'(mc.val == MAX));
    chk("w.value",   32'(value_w),   32'(mw.val));
    chk("w.changed", 32'(changed_w), 32'(mw.changed));
    chk("w.coarse",  32'(coarse_w),  32'(mw.coarse));
    chk("w.accel",   32'(lvl_w),     32'(mw.lvl));
    chk("w.at_min",  32'(at_min_w),  32'(mw.val == MIN));
    chk("w.at_max",  32'(at_max_w),  32'(mw.val == MAX));
  endtask

  // One clock with the given pulses; outputs checked 1 time unit after the edge.
  task automatic cycle(input bit icw, input bit iccw, input bit iprs, input bit ild,
                       input int lv);
    cw = icw; ccw = iccw; prs = iprs; load = ild; load_val = 16'(lv);
    @(posedge clk);
    if (rst) begin
      mc = mstep(mc, icw, iccw, iprs, ild, lv, 1'b0);
      mw = mstep(mw, icw, iccw, iprs, ild, lv, 1'b1);
    end
    #1;
    cw = 0; ccw = 0; prs = 0; load = 0; load_val = '0;
    compare_models();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mc = mreset();
    mw = mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit cw, ccw, prs, ld;
    int lv;
    int vc; bit chc;
    int vw; bit chw;
    bit crs;
  } vec_t;

  vec_t tbl[15];

  int exp_v[9];
  int exp_l[9];
  int gap, r, lv;
  bit rcw, rccw, rprs, rld;
  int bias;

  initial begin
    cw = 0; ccw = 0; prs = 0; load = 0; load_val = '0;

    //                cw ccw prs ld  lv    vc  chc  vw  chw crs
    tbl[0]  = '{0, 0, 1, 0,    0,  500, 0,  500, 0, 1};
    tbl[1]  = '{1, 0, 0, 0,    0,  510, 1,  510, 1, 1};
    tbl[2]  = '{0, 0, 0, 1,  995,  995, 1,  995, 1, 1};
    tbl[3]  = '{1, 0, 0, 0,    0, 1000, 1,    0, 1, 1};
    tbl[4]  = '{1, 0, 0, 0,    0, 1000, 0,   10, 1, 1};
    tbl[5]  = '{0, 0, 0, 1, 1000, 1000, 0, 1000, 1, 1};
    tbl[6]  = '{0, 0, 1, 0,    0, 1000, 0, 1000, 0, 0};
    tbl[7]  = '{1, 0, 0, 0,    0, 1000, 0,    0, 1, 0};
    tbl[8]  = '{0, 1, 0, 0,    0,  999, 1, 1000, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 2000, 1000, 1, 1000, 0, 0};
    tbl[10] = '{1, 1, 0, 0,    0, 1000, 0, 1000, 0, 0};
    tbl[11] = '{0, 0, 0, 1,    0,    0, 1,    0, 1, 0};
    tbl[12] = '{0, 1, 0, 0,    0,    0, 0, 1000, 1, 0};
    tbl[13] = '{1, 0, 1, 0,    0,    1, 1,    0, 1, 1};
    tbl[14] = '{1, 1, 1, 1,    7,    7, 1,    7, 1, 1};

    exp_v = '{501, 502, 503, 504, 508, 512, 516, 520, 536};
    exp_l = '{0, 0, 0, 1, 1, 1, 1, 2, 2};

    // Reset state
    do_reset();
    #1;
    compare_models();
    chk("reset.value", 32'(value_c), 32'(INIT));

    // Slow rotation: each detent times out, so no acceleration
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0);
      chk("slow.value", 32'(value_c), 32'(501 + i));
      chk("slow.changed", 32'(changed_c), 32'd1);
      chk("slow.accel", 32'(lvl_c), 32'd0);
      idle(199);
    end

    // Fast rotation: x1, x4, x16, then window expiry
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 0, 0, 0);
      chk("fast.value", 32'(value_c), 32'(exp_v[i]));
      chk("fast.accel", 32'(lvl_c), 32'(exp_l[i]));
      if (i < 8) idle(9);
    end
    idle(99);
    chk("window.edge_accel", 32'(lvl_c), 32'd2);
    idle(1);
    chk("window.expired_accel", 32'(lvl_c), 32'd0);

    // Table: coarse, bounds, wrap, load clamp, priorities
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].cw, tbl[i].ccw, tbl[i].prs, tbl[i].ld, tbl[i].lv);
      chk($sformatf("tbl%0d.c.value", i), 32'(value_c), 32'(tbl[i].vc));
      chk($sformatf("tbl%0d.c.changed", i), 32'(changed_c), 32'(tbl[i].chc));
      chk($sformatf("tbl%0d.w.value", i), 32'(value_w), 32'(tbl[i].vw));
      chk($sformatf("tbl%0d.w.changed", i), 32'(changed_w), 32'(tbl[i].chw));
      chk($sformatf("tbl%0d.coarse", i), 32'(coarse_c), 32'(tbl[i].crs));
    end

    // Reversal steps x1 and drops acceleration
    do_reset();
    repeat (4) cycle(1, 0, 0, 0, 0);
    chk("rev.pre_value", 32'(value_c), 32'd504);
    chk("rev.pre_accel", 32'(lvl_c), 32'd1);
    cycle(0, 1, 0, 0, 0);
    chk("rev.value", 32'(value_c), 32'd503);
    chk("rev.accel", 32'(lvl_c), 32'd0);
    cycle(1, 1, 0, 0, 0);
    chk("both.value", 32'(value_c), 32'd503);
    chk("both.changed", 32'(changed_c), 32'd0);

    // Asynchronous reset mid-acceleration, between clock edges
    do_reset();
    cycle(0, 0, 1, 0, 0);
    repeat (8) cycle(1, 0, 0, 0, 0);
    chk("arst.pre_accel", 32'(lvl_c), 32'd2);
    chk("arst.pre_value", 32'(value_c), 32'd700);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.value", 32'(value_c), 32'(INIT));
    chk("arst.changed", 32'(changed_c), 32'd0);
    chk("arst.coarse", 32'(coarse_c), 32'd0);
    chk("arst.accel", 32'(lvl_c), 32'd0);
    chk("arst.w.value", 32'(value_w), 32'(INIT));
    mc = mreset();
    mw = mreset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the models
    bias = 1;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 19) == 0) bias = -bias;
      r    = $urandom_range(0, 9);
      rcw  = 0; rccw = 0;
      if (r < 5)       begin if (bias > 0) rcw = 1; else rccw = 1; end
      else if (r < 7)  begin if (bias > 0) rccw = 1; else rcw = 1; end
      else if (r == 7) begin rcw = 1; rccw = 1; end
      rprs = ($urandom_range(0, 9) == 0);
      rld  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       lv = $urandom_range(0, 20);
        1:       lv = $urandom_range(980, 1200);
        2:       lv = $urandom_range(0, 65535);
        default: lv = $urandom_range(0, 1000);
      endcase
      cycle(rcw, rccw, rprs, rld, lv);
      r = $urandom_range(0, 99);
      if (r < 70)      gap = $urandom_range(0, 3);
      else if (r < 96) gap = $urandom_range(4, 20);
      else             gap = $urandom_range(95, 105);
      idle(gap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
